uart_cmd_frame_encoder: RTL and testbench

Parametrised, sequential successor to the combinational header encoder. Accepts one APB write/read request per handshake and prepends the write/read header byte. Serialises the frame MSB-byte-first onto an 8-bit valid/ready stream feeding the UART TX. Adds optional XOR checksum and short read frames (address only).

---
 rtl/uart_apb_pkg.sv | 17 +
 rtl/frame_shift_reg.sv | 30 +++
 rtl/uart_cmd_frame_encoder.sv | 116 +++++++++++
 tb/tb_uart_cmd_frame_encoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared constants and FSM state type for the UART command framer.
// Byte width, default header bytes and the frame FSM states.
package uart_apb_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] WR_HEAD_DEF = 8'h02;
  localparam logic [7:0] RD_HEAD_DEF = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    CHK
  } state_t;

endpackage

// File: rtl/frame_shift_reg.sv
// Loadable left-shifting frame register; exposes its top byte.
// Ports: clk, rst, load, shift, din[W], top[8].
module frame_shift_reg
  import uart_apb_pkg::*;
#(
  parameter int W = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [W-1:0]        din,
  input  logic                shift,
  output logic [BYTE_W-1:0]   top
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  assign top = sr[W-1 -: BYTE_W];

endmodule

// File: rtl/uart_cmd_frame_encoder.sv
// Frames one APB request as header + addr/data (+ XOR) byte stream.
// Ports: clk, rst, req_* (valid/ready in), tx_* (valid/ready out), busy.
module uart_cmd_frame_encoder
  import uart_apb_pkg::*;
#(
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] WR_HEAD  = WR_HEAD_DEF,
  parameter logic [7:0] RD_HEAD  = RD_HEAD_DEF,
  parameter bit         RD_SHORT = 1'b0,
  parameter bit         CHK_EN   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_wr,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int W  = ADDR_W + DATA_W;
  localparam int NB = W / BYTE_W;
  localparam int CW = $clog2(NB + 1);

  localparam logic [CW-1:0] N_FULL  = CW'(NB);
  localparam logic [CW-1:0] N_SHORT = CW'(ADDR_W / BYTE_W);

  if ((ADDR_W % BYTE_W) != 0 || ADDR_W < BYTE_W ||
      (DATA_W % BYTE_W) != 0 || DATA_W < BYTE_W) begin : g_bad_w
    $error("ADDR_W/DATA_W must be byte multiples >= 8");
  end

  state_t         state;
  state_t         nxt;
  logic [7:0]     head;
  logic [7:0]     chk;
  logic [7:0]     top;
  logic [CW-1:0]  cnt;
  logic           acc;
  logic           shift;

  assign acc   = req_valid && req_ready;
  assign shift = (state == BODY) && tx_ready;

  frame_shift_reg #(
    .W (W)
  ) u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (acc),
    .din   ({req_addr, req_data}),
    .shift (shift),
    .top   (top)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head  <= '0;
      chk   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        head <= req_wr ? WR_HEAD : RD_HEAD;
        cnt  <= (req_wr || !RD_SHORT) ? N_FULL : N_SHORT;
      end
      if (state == HEAD && tx_ready) begin
        chk <= head;
      end
      if (shift) begin
        chk <= chk ^ top;
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        // held low while reset is asserted
        req_ready = !rst;
        if (acc) nxt = HEAD;
      end
      HEAD: begin
        tx_valid = 1'b1;
        tx_data  = head;
        if (tx_ready) nxt = BODY;
      end
      BODY: begin
        tx_valid = 1'b1;
        tx_data  = top;
        if (tx_ready && cnt == CW'(1)) begin
          nxt = CHK_EN ? CHK : IDLE;
        end
      end
      CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk;
        if (tx_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_frame_encoder.sv
// Scoreboard bench for uart_cmd_frame_encoder, three parameter sets.
// a: defaults, b: RD_SHORT+CHK_EN, c: 8/8 widths with CHK_EN.
module tb_uart_cmd_frame_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [7:0]  c_addr, c_data;
  logic a_wr, a_val, a_rdy, a_txv, a_txr, a_busy;
  logic b_wr, b_val, b_rdy, b_txv, b_txr, b_busy;
  logic c_wr, c_val, c_rdy, c_txv, c_txr, c_busy;
  logic [7:0] a_txd, b_txd, c_txd;

  uart_cmd_frame_encoder dut_a (
    .clk(clk), .rst(rst),
    .req_addr(a_addr), .req_data(a_data),
    .req_wr(a_wr), .req_valid(a_val), .req_ready(a_rdy),
    .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr),
    .busy(a_busy)
  );

  uart_cmd_frame_encoder #(
    .RD_SHORT(1'b1), .CHK_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_addr(b_addr), .req_data(b_data),
    .req_wr(b_wr), .req_valid(b_val), .req_ready(b_rdy),
    .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_txr),
    .busy(b_busy)
  );

  uart_cmd_frame_encoder #(
    .ADDR_W(8), .DATA_W(8), .CHK_EN(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst),
    .req_addr(c_addr), .req_data(c_data),
    .req_wr(c_wr), .req_valid(c_val), .req_ready(c_rdy),
    .tx_data(c_txd), .tx_valid(c_txv), .tx_ready(c_txr),
    .busy(c_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference framer: header, addr bytes, data bytes, optional XOR
  task automatic exp_frame(int d, logic [63:0] a, int aw,
                           logic [63:0] dt, int dw, bit wr,
                           bit sh, bit ce);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(wr ? 8'h02 : 8'h03);
    for (int i = aw / 8 - 1; i >= 0; i--) b.push_back(a[i*8 +: 8]);
    if (wr || !sh) begin
      for (int i = dw / 8 - 1; i >= 0; i--) b.push_back(dt[i*8 +: 8]);
    end
    if (ce) begin
      x = 8'h00;
      foreach (b[i]) x = x ^ b[i];
      b.push_back(x);
    end
    foreach (b[i]) begin
      case (d)
        0: q_a.push_back(b[i]);
        1: q_b.push_back(b[i]);
        default: q_c.push_back(b[i]);
      endcase
    end
  endtask

  task automatic wait_done(int d, string tag);
    bit ok;
    int sz;
    logic rd, bz;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      case (d)
        0: begin sz = q_a.size(); rd = a_rdy; bz = a_busy; end
        1: begin sz = q_b.size(); rd = b_rdy; bz = b_busy; end
        default: begin sz = q_c.size(); rd = c_rdy; bz = c_busy; end
      endcase
      if (sz == 0 && rd && !bz) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, ok, 1'b1);
  endtask

  logic a_st, b_st, c_st;
  logic [7:0] a_hd, b_hd, c_hd;

  always @(negedge clk) begin
    if (rst) begin
      a_st <= 1'b0;
    end else begin
      if (a_st) begin
        check("a_hold_v", a_txv, 1'b1);
        check("a_hold_d", a_txd, a_hd);
      end
      if (a_txv && a_txr) begin
        if (q_a.size() == 0) check("a_extra", a_txd, 8'hxx);
        else check("a_byte", a_txd, q_a.pop_front());
      end
      a_st <= a_txv && !a_txr;
      a_hd <= a_txd;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_st <= 1'b0;
    end else begin
      if (b_st) begin
        check("b_hold_v", b_txv, 1'b1);
        check("b_hold_d", b_txd, b_hd);
      end
      if (b_txv && b_txr) begin
        if (q_b.size() == 0) check("b_extra", b_txd, 8'hxx);
        else check("b_byte", b_txd, q_b.pop_front());
      end
      b_st <= b_txv && !b_txr;
      b_hd <= b_txd;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      c_st <= 1'b0;
    end else begin
      if (c_st) begin
        check("c_hold_v", c_txv, 1'b1);
        check("c_hold_d", c_txd, c_hd);
      end
      if (c_txv && c_txr) begin
        if (q_c.size() == 0) check("c_extra", c_txd, 8'hxx);
        else check("c_byte", c_txd, q_c.pop_front());
      end
      c_st <= c_txv && !c_txr;
      c_hd <= c_txd;
    end
  end

  initial begin
    int k, first, second, nacc, idle_n;
    bit acc;
    a_addr = '0; a_data = '0; a_wr = 0; a_val = 0; a_txr = 1;
    b_addr = '0; b_data = '0; b_wr = 0; b_val = 0; b_txr = 1;
    c_addr = '0; c_data = '0; c_wr = 0; c_val = 0; c_txr = 1;

    // reset state
    step();
    step();
    check("rst_rdy", a_rdy, 1'b0);
    check("rst_txv", a_txv, 1'b0);
    check("rst_txd", a_txd, 8'h00);
    check("rst_busy", a_busy, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_rdy", a_rdy, 1'b1);
    step();

    // default write, latency and ready gap
    a_addr = 16'h1234; a_data = 32'hDEADBEEF; a_wr = 1; a_val = 1;
    exp_frame(0, 64'h1234, 16, 64'hDEADBEEF, 32, 1, 0, 0);
    step();
    a_val = 0;
    check("t1_lat_v", a_txv, 1'b1);
    check("t1_lat_d", a_txd, 8'h02);
    check("t1_busy", a_busy, 1'b1);
    check("t1_nordy", a_rdy, 1'b0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (a_rdy) begin
        k = i;
        break;
      end
    end
    check("t1_rdy_gap", k, 7);
    check("t1_drain", q_a.size(), 0);

    // short read with checksum
    b_addr = 16'hA55A; b_data = 32'h13579BDF; b_wr = 0; b_val = 1;
    exp_frame(1, 64'hA55A, 16, 64'h0, 32, 0, 1, 1);
    step();
    b_val = 0;
    b_data = 32'hFFFFFFFF;
    wait_done(1, "t2_done");

    // checksum write on b
    b_addr = 16'h1234; b_data = 32'hDEADBEEF; b_wr = 1; b_val = 1;
    exp_frame(1, 64'h1234, 16, 64'hDEADBEEF, 32, 1, 1, 1);
    step();
    b_val = 0;
    wait_done(1, "t2b_done");

    // backpressure
    a_addr = 16'h0001; a_data = 32'h00000002; a_wr = 1; a_val = 1;
    exp_frame(0, 64'h0001, 16, 64'h2, 32, 1, 0, 0);
    step();
    a_val = 0;
    for (int i = 0; i < 200; i++) begin
      case (i)
        0: a_txr = 1;
        1: a_txr = 0;
        2: a_txr = 0;
        3: a_txr = 1;
        default: a_txr = 1'($urandom_range(0, 1));
      endcase
      step();
      if (a_rdy && q_a.size() == 0) break;
    end
    a_txr = 1;
    wait_done(0, "t3_done");

    // back-to-back with held valid
    a_addr = 16'h1234; a_data = 32'hDEADBEEF; a_wr = 1; a_val = 1;
    exp_frame(0, 64'h1234, 16, 64'hDEADBEEF, 32, 1, 0, 0);
    exp_frame(0, 64'hBEEF, 16, 64'hCAFEF00D, 32, 0, 0, 0);
    nacc = 0; first = -1; second = -1; idle_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = a_val && a_rdy;
      step();
      if (acc) begin
        if (nacc == 0) begin
          first = cyc;
          a_addr = 16'hBEEF; a_data = 32'hCAFEF00D; a_wr = 0;
        end else begin
          second = cyc;
          a_val = 0;
        end
        nacc++;
      end else if (nacc == 1 && !a_busy) begin
        idle_n++;
      end
      if (nacc == 2) break;
    end
    a_val = 0;
    check("t4_gap", second - first, 8);
    check("t4_idle", idle_n, 1);
    wait_done(0, "t4_done");

    // reset mid-frame after three bytes
    a_addr = 16'h5678; a_data = 32'h9ABCDEF0; a_wr = 1; a_val = 1;
    q_a.push_back(8'h02);
    q_a.push_back(8'h56);
    q_a.push_back(8'h78);
    step();
    a_val = 0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_txv", a_txv, 1'b0);
    check("t5_busy", a_busy, 1'b0);
    check("t5_txd", a_txd, 8'h00);
    check("t5_q", q_a.size(), 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("t5_rdy", a_rdy, 1'b1);
    a_addr = 16'h0BAD; a_data = 32'h11223344; a_wr = 0; a_val = 1;
    exp_frame(0, 64'h0BAD, 16, 64'h11223344, 32, 0, 0, 0);
    step();
    a_val = 0;
    check("t5_head", a_txd, 8'h03);
    wait_done(0, "t5_done");

    // narrow widths with checksum
    c_addr = 8'h10; c_data = 8'h20; c_wr = 1; c_val = 1;
    q_c.push_back(8'h02);
    q_c.push_back(8'h10);
    q_c.push_back(8'h20);
    q_c.push_back(8'h32);
    step();
    c_val = 0;
    wait_done(2, "t6_done");

    step();
    step();
    check("end_qa", q_a.size(), 0);
    check("end_qb", q_b.size(), 0);
    check("end_qc", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
